// File: rtl/inst_cache.sv
// +---------------------------------------------------------------------------+
// | inst_cache : direct-mapped read-only instruction cache with block refill   |
// | Rev 1.0    : optional hit/miss counters under INST_CACHE_STATS_EN          |
// +---------------------------------------------------------------------------+
`default_nettype none

module inst_cache #(
    parameter int NUM_LINES       = 64,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        cache_en,
    input  logic        flush,
    input  logic [31:0] pc,
    output logic [31:0] inst,
    output logic        hit,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
`ifdef INST_CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int WOFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - 2 - WOFF_W - IDX_W;
    localparam int IDX_LO = 2 + WOFF_W;

    localparam logic [31:0]       C_OFF_MASK  = 32'(WORDS_PER_BLOCK * 4 - 1);
    localparam logic [WOFF_W-1:0] C_LAST_BEAT = WOFF_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         blk_addr_q, blk_addr_d;
    logic [WOFF_W-1:0]   cnt_q, cnt_d;
    logic                flush_seen_q, flush_seen_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][WORDS_PER_BLOCK];

    logic [WOFF_W-1:0] pc_word;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              fill_beat;
    logic              fill_last;
    logic              miss_start;
    logic              bypass;
    logic              unused_pc_bits;

    assign pc_word        = pc[2 +: WOFF_W];
    assign pc_idx         = pc[IDX_LO +: IDX_W];
    assign pc_tag         = pc[31 -: TAG_W];
    assign unused_pc_bits = ^pc[1:0];

    assign fill_idx  = blk_addr_q[IDX_LO +: IDX_W];
    assign fill_tag  = blk_addr_q[31 -: TAG_W];
    assign fill_beat = (state_q == FILL) && mem_rvalid;
    assign fill_last = fill_beat && (cnt_q == C_LAST_BEAT);

    // Bypass only takes effect from IDLE so a fill in progress always completes.
    assign bypass = (state_q == IDLE) && !cache_en;

    assign hit = cache_en && (state_q == IDLE) && valid_q[pc_idx]
                 && (tag_q[pc_idx] == pc_tag);

    assign inst     = bypass ? mem_rdata : data_q[pc_idx][pc_word];
    assign mem_req  = (state_q == REQ) || bypass;
    assign mem_addr = bypass ? pc : blk_addr_q;

    always_comb begin
        state_d      = state_q;
        blk_addr_d   = blk_addr_q;
        cnt_d        = cnt_q;
        miss_start   = 1'b0;
        flush_seen_d = (state_q == IDLE) ? 1'b0 : (flush_seen_q || flush);
        case (state_q)
            IDLE: begin
                if (cache_en && !hit) begin
                    state_d    = REQ;
                    blk_addr_d = pc & ~C_OFF_MASK;
                    miss_start = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                if (mem_rvalid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == C_LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            blk_addr_q   <= '0;
            cnt_q        <= '0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            blk_addr_q   <= blk_addr_d;
            cnt_q        <= cnt_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    // A flush on the closing beat edge takes priority, leaving the line invalid.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (fill_last) begin
            valid_q[fill_idx] <= !flush_seen_q;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_beat) begin
            data_q[fill_idx][cnt_q] <= mem_rdata;
            if (fill_last) begin
                tag_q[fill_idx] <= fill_tag;
            end
        end
    end

`ifdef INST_CACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (hit && (hit_count_q != 32'hFFFF_FFFF)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (miss_start && (miss_count_q != 32'hFFFF_FFFF)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_cache.sv
// +---------------------------------------------------------------------------+
// | tb_inst_cache : directed self-checking bench for inst_cache                |
// | Rev 1.0       : counter checks compiled in with INST_CACHE_STATS_EN        |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_inst_cache;

    logic        clk;
    logic        rst_b;
    logic        cache_en;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        hit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef INST_CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int tests_run;
    int tests_failed;

    inst_cache #(
        .NUM_LINES       (64),
        .WORDS_PER_BLOCK (4)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .cache_en   (cache_en),
        .flush      (flush),
        .pc         (pc),
        .inst       (inst),
        .hit        (hit),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
`ifdef INST_CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in IDLE with pc missing; flush is pulsed on beat flush_beat (>3 = never).
    task automatic do_miss(input logic [31:0] addr, input logic [31:0] d0, input int flush_beat);
        #1;
        chk("miss_hit", {31'd0, hit}, 32'd0);
        tick();
        chk("req_assert", {31'd0, mem_req}, 32'd1);
        chk("req_addr", mem_addr, addr);
        tick();
        chk("req_hold", {31'd0, mem_req}, 32'd1);
        chk("req_addr_hold", mem_addr, addr);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("req_drop", {31'd0, mem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = d0 + 32'(i);
            flush      = (i == flush_beat);
            #1;
            chk("fill_nohit", {31'd0, hit}, 32'd0);
            tick();
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        flush      = 1'b0;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_b      = 1'b0;
        cache_en   = 1'b1;
        flush      = 1'b0;
        pc         = 32'h40;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        tick();
        tick();
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_hit", {31'd0, hit}, 32'd0);
        rst_b = 1'b1;

        // Cold miss and refill
        do_miss(32'h40, 32'hA0, 9);
        chk("cold_hit", {31'd0, hit}, 32'd1);
        chk("cold_inst", inst, 32'hA0);
        pc = 32'h44; #1;
        chk("w1_hit", {31'd0, hit}, 32'd1);
        chk("w1_inst", inst, 32'hA1);
        pc = 32'h4C; #1;
        chk("w3_inst", inst, 32'hA3);
        tick();

        // Conflict eviction
        pc = 32'h440;
        do_miss(32'h440, 32'hB0, 9);
        chk("evict_hit", {31'd0, hit}, 32'd1);
        chk("evict_inst", inst, 32'hB0);
        pc = 32'h448; #1;
        chk("evict_inst2", inst, 32'hB2);
        pc = 32'h40;
        do_miss(32'h40, 32'hC0, 1);
        chk("flush2_hit", {31'd0, hit}, 32'd0);
        do_miss(32'h40, 32'hD0, 3);
        chk("flushlast_hit", {31'd0, hit}, 32'd0);
        do_miss(32'h40, 32'hA0, 9);
        chk("refill_hit", {31'd0, hit}, 32'd1);
        chk("refill_inst", inst, 32'hA0);

        // Bypass
        cache_en  = 1'b0;
        pc        = 32'h100;
        mem_rdata = 32'hDEADBEEF;
        #1;
        chk("byp_inst", inst, 32'hDEADBEEF);
        chk("byp_req", {31'd0, mem_req}, 32'd1);
        chk("byp_addr", mem_addr, 32'h100);
        chk("byp_hit", {31'd0, hit}, 32'd0);
        tick();
        tick();
        chk("byp_req2", {31'd0, mem_req}, 32'd1);
        chk("byp_addr2", mem_addr, 32'h100);
        cache_en  = 1'b1;
        mem_rdata = 32'h0;
        do_miss(32'h100, 32'hE0, 9);
        chk("after_byp_inst", inst, 32'hE0);

        // Reset in the middle of a fill
        pc = 32'h240;
        #1;
        chk("rf_miss", {31'd0, hit}, 32'd0);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55;
        tick();
        tick();
        mem_rvalid = 1'b0;
        rst_b      = 1'b0;
        #1;
        chk("rf_req_drop", {31'd0, mem_req}, 32'd0);
        chk("rf_addr", mem_addr, 32'h0);
        tick();
        rst_b      = 1'b1;
        pc         = 32'h40;
        mem_rvalid = 1'b1;
        #1;
        chk("rf_inval", {31'd0, hit}, 32'd0);
        tick();
        chk("rf_req", {31'd0, mem_req}, 32'd1);
        chk("rf_req_addr", mem_addr, 32'h40);
        tick();
        chk("rf_stray", {31'd0, mem_req}, 32'd1);
        mem_rvalid = 1'b0;
        mem_ack    = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hF0 + 32'(i);
            tick();
        end
        mem_rvalid = 1'b0;
        #1;
        chk("rf_hit", {31'd0, hit}, 32'd1);
        chk("rf_inst", inst, 32'hF0);

`ifdef INST_CACHE_STATS_EN
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        pc    = 32'h40;
        do_miss(32'h40, 32'hA0, 9);
        tick();
        pc = 32'h44;
        tick();
        pc = 32'h48;
        tick();
        cache_en = 1'b0;
        tick();
        chk("st_miss", miss_count, 32'd1);
        chk("st_hit", hit_count, 32'd3);
        cache_en = 1'b1;
        @(negedge clk);
        dut.hit_count_q = 32'hFFFF_FFFF;
        tick();
        tick();
        chk("st_sat", hit_count, 32'hFFFF_FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
